// File: rtl/mc_alu_exec_pkg.sv
// rtl/mc_alu_exec_pkg.sv - shared encodings and shift helper for the multi-cycle execute unit
// Contents: alu_op_e (3-bit ALU op), SHIFT_* funct[1:0] encodings,
// shift_step() single-bit shift used by the iterative shifter.
package mc_alu_exec_pkg;

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_ADD  = 3'b010,
    ALU_XOR  = 3'b011,
    ALU_NOR  = 3'b100,
    ALU_SLTU = 3'b101,
    ALU_SUB  = 3'b110,
    ALU_SLT  = 3'b111
  } alu_op_e;

  localparam logic [1:0] SHIFT_SLL = 2'b00;
  localparam logic [1:0] SHIFT_SRL = 2'b10;
  localparam logic [1:0] SHIFT_SRA = 2'b11;

  // One shifter step; funct 01 has no MIPS meaning here and falls back to SLL.
  function automatic logic [31:0] shift_step(input logic [31:0] v, input logic [1:0] st);
    logic [31:0] r;
    case (st)
      SHIFT_SRL: r = {1'b0, v[31:1]};
      SHIFT_SRA: r = {v[31], v[31:1]};
      default:   r = {v[30:0], 1'b0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mc_alu_exec_alu_comb.sv
// rtl/mc_alu_exec_alu_comb.sv - combinational 8-op logic/arithmetic unit
// Ports: alu_op (3-bit op), a, b (operands), y (result).
// ADD/SUB wrap modulo 2^WIDTH; SLT/SLTU yield a zero-extended 0/1.
module alu_comb
  import mc_alu_exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (alu_op_e'(alu_op))
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_ADD:  y = a + b;
      ALU_XOR:  y = a ^ b;
      ALU_NOR:  y = ~(a | b);
      ALU_SLTU: y = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_SUB:  y = a - b;
      ALU_SLT:  y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/mc_alu_exec.sv
// rtl/mc_alu_exec.sv - multi-cycle execute unit: 1-cycle ALU ops, bit-serial shifts
// Ports: clk, rst (sync, active high); request side in_valid/in_ready with
// alu_op, enableshifter, shift_type, shift, shamt, src_a, src_b;
// response side out_valid/out_ready with registered result and zero.
module mc_alu_exec
  import mc_alu_exec_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         alu_op,
  input  logic               enableshifter,
  input  logic [1:0]         shift_type,
  input  logic               shift,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e             state;
  logic [SHAMT_W-1:0] count;
  logic [WIDTH-1:0]   work;
  logic [1:0]         stype;

  logic [WIDTH-1:0]   alu_y;
  logic [WIDTH-1:0]   work_next;
  logic [SHAMT_W-1:0] amt;

  alu_comb #(.WIDTH(WIDTH)) u_alu (
    .alu_op (alu_op),
    .a      (src_a),
    .b      (src_b),
    .y      (alu_y)
  );

  assign amt       = shift ? src_a[SHAMT_W-1:0] : shamt;
  assign work_next = shift_step(work, stype);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      count     <= '0;
      work      <= '0;
      stype     <= SHIFT_SLL;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (!enableshifter) begin
              result    <= alu_y;
              zero      <= (alu_y == '0);
              out_valid <= 1'b1;
              state     <= S_DONE;
            end else begin
              stype <= shift_type;
              work  <= src_b;
              count <= amt;
              if (amt == '0) begin
                result    <= src_b;
                zero      <= (src_b == '0);
                out_valid <= 1'b1;
                state     <= S_DONE;
              end else begin
                state <= S_SHIFT;
              end
            end
          end
        end
        S_SHIFT: begin
          work  <= work_next;
          count <= count - 1'b1;
          // count==1 means this edge performs the last bit of the shift
          if (count == SHAMT_W'(1)) begin
            result    <= work_next;
            zero      <= (work_next == '0);
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          // in_ready rises only after the handshake edge, so no same-cycle reaccept
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_alu_exec.sv
// tb/tb_mc_alu_exec.sv - directed self-checking bench for mc_alu_exec
module tb_mc_alu_exec;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_op;
  logic        enableshifter;
  logic [1:0]  shift_type;
  logic        shift;
  logic [4:0]  shamt;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mc_alu_exec #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .alu_op        (alu_op),
    .enableshifter (enableshifter),
    .shift_type    (shift_type),
    .shift         (shift),
    .shamt         (shamt),
    .src_a         (src_a),
    .src_b         (src_b),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result),
    .zero          (zero)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request at a negedge; it is accepted at the following posedge.
  task automatic issue(input logic [2:0] op, input logic en, input logic [1:0] st,
                       input logic sh, input logic [4:0] sa,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    alu_op = op; enableshifter = en; shift_type = st; shift = sh; shamt = sa;
    src_a = a; src_b = b; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Edges after the accept edge until out_valid is seen (bounded).
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, ".in_ready_after"}, 32'(in_ready), 32'd1);
    check_eq({tag, ".out_valid_after"}, 32'(out_valid), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic en,
                        input logic [1:0] st, input logic sh, input logic [4:0] sa,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input logic exp_z, input int exp_lat);
    int lat;
    issue(op, en, st, sh, sa, a, b);
    wait_valid(lat);
    check_eq({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, ".result"}, result, exp_r);
    check_eq({tag, ".zero"}, 32'(zero), 32'(exp_z));
    consume(tag);
  endtask

  initial begin
    int lat;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = 3'b000; enableshifter = 1'b0; shift_type = 2'b00; shift = 1'b0;
    shamt = 5'd0; src_a = 32'd0; src_b = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset.in_ready", 32'(in_ready), 32'd1);
    check_eq("reset.out_valid", 32'(out_valid), 32'd0);
    check_eq("reset.result", result, 32'd0);
    check_eq("reset.zero", 32'(zero), 32'd0);
    rst = 1'b0;

    // ALU ops: tag, op, en, st, sh, shamt, a, b, result, zero, latency
    run_op("add_wrap", 3'b010, 0, 2'b00, 0, 5'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0);
    run_op("add_mod",  3'b010, 0, 2'b00, 0, 5'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 0);
    run_op("slt",      3'b111, 0, 2'b00, 0, 5'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 0);
    run_op("sltu",     3'b101, 0, 2'b00, 0, 5'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 0);
    run_op("sub_zero", 3'b110, 0, 2'b00, 0, 5'd0, 32'd5,        32'd5,        32'h00000000, 1, 0);
    run_op("and",      3'b000, 0, 2'b00, 0, 5'd0, 32'hF0F000FF, 32'h0FF00F0F, 32'h00F0000F, 0, 0);
    run_op("or",       3'b001, 0, 2'b00, 0, 5'd0, 32'hF0F000FF, 32'h0FF00F0F, 32'hFFF00FFF, 0, 0);
    run_op("xor",      3'b011, 0, 2'b00, 0, 5'd0, 32'hF0F000FF, 32'h0FF00F0F, 32'hFF000FF0, 0, 0);
    run_op("nor",      3'b100, 0, 2'b00, 0, 5'd0, 32'hF0F000FF, 32'h0FF00F0F, 32'h000FF000, 0, 0);

    // Shifts: alu_op deliberately nonzero to show it is ignored
    run_op("sra31",    3'b010, 1, 2'b11, 1, 5'd0, 32'h0000001F, 32'h80000000, 32'hFFFFFFFF, 0, 31);
    run_op("srl31",    3'b010, 1, 2'b10, 1, 5'd0, 32'h0000001F, 32'h80000000, 32'h00000001, 0, 31);
    run_op("sll0",     3'b010, 1, 2'b00, 0, 5'd0, 32'h0000001F, 32'h12345678, 32'h12345678, 0, 0);
    run_op("sll01",    3'b000, 1, 2'b01, 0, 5'd1, 32'd0,        32'h80000001, 32'h00000002, 0, 1);
    run_op("sra_pos",  3'b000, 1, 2'b11, 0, 5'd4, 32'd0,        32'h70000000, 32'h07000000, 0, 4);
    run_op("sll_out",  3'b000, 1, 2'b00, 0, 5'd4, 32'd0,        32'hF0000000, 32'h00000000, 1, 4);

    // Busy: second request while shifting must be ignored
    issue(3'b000, 1, 2'b00, 0, 5'd4, 32'd0, 32'h12345678);
    check_eq("busy.in_ready", 32'(in_ready), 32'd0);
    enableshifter = 1'b0; alu_op = 3'b010; src_a = 32'd1; src_b = 32'd1; in_valid = 1'b1;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    wait_valid(lat);
    check_eq("busy.latency", 32'(lat + 2), 32'd4);
    check_eq("busy.result", result, 32'h23456780);
    consume("busy");
    check_eq("busy.no_second", 32'(out_valid), 32'd0);

    // Backpressure: result held while out_ready low
    issue(3'b010, 0, 2'b00, 0, 5'd0, 32'd3, 32'd4);
    for (int i = 0; i < 10; i++) begin
      check_eq("bp.out_valid", 32'(out_valid), 32'd1);
      check_eq("bp.result", result, 32'd7);
      check_eq("bp.in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    consume("bp");

    // Reset during a long shift abandons it
    issue(3'b000, 1, 2'b00, 0, 5'd20, 32'd0, 32'h00000001);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_mid.out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_mid.result", result, 32'd0);
    check_eq("rst_mid.in_ready", 32'(in_ready), 32'd1);
    repeat (25) @(negedge clk);
    check_eq("rst_mid.no_late", 32'(out_valid), 32'd0);
    run_op("add_after_rst", 3'b010, 0, 2'b00, 0, 5'd0, 32'd2, 32'd3, 32'd5, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
